// File: rtl/decode_stage.sv
// RV32I(+M) decode pipeline stage: registered output, one-entry skid buffer, flush,
// strict legality checking and a saturating illegal-instruction counter.
package decode_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_COPY = 4'd10
  } alu_op_e;

  typedef enum logic {ALU_SRC_RS1 = 1'b0, ALU_SRC_PC = 1'b1} alu_src_a_e;
  typedef enum logic {ALU_SRC_REG = 1'b0, ALU_SRC_IMM = 1'b1} alu_src_b_e;
  typedef enum logic [1:0] {MEM_NOP = 2'd0, MEM_B = 2'd1, MEM_H = 2'd2, MEM_W = 2'd3} mem_op_e;
  typedef enum logic [1:0] {WB_SRC_ALU = 2'd0, WB_SRC_MEM = 2'd1, WB_SRC_PC4 = 2'd2} wb_src_e;

  // All-zero encoding is the decoder default bundle.
  typedef struct packed {
    alu_op_e    alu_op;
    alu_src_a_e alu_src_a;
    alu_src_b_e alu_src_b;
    logic       reg_write;
    wb_src_e    wb_src;
    logic       mem_read;
    logic       mem_write;
    mem_op_e    mem_op;
    logic       is_unsigned;
    logic       branch;
    logic [2:0] br_op;
    logic       jump;
    logic       jalr;
  } control_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
endpackage

module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter bit          ENABLE_M  = 1'b0,
  parameter int unsigned ILL_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [XLEN-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [4:0]           out_rs1,
  output logic [4:0]           out_rs2,
  output logic [4:0]           out_rd,
  output logic [XLEN-1:0]      out_imm,
  output control_t             out_ctrl,
  output logic                 out_is_muldiv,
  output logic [2:0]           out_muldiv_op,
  output logic                 out_ecall,
  output logic                 out_ebreak,
  output logic                 out_illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    control_t        ctrl;
    logic            is_muldiv;
    logic [2:0]      muldiv_op;
    logic            ecall;
    logic            ebreak;
    logic            illegal;
  } pkt_t;

  function automatic alu_op_e f_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f_alu = alt ? ALU_SUB : ALU_ADD;
      3'b001:  f_alu = ALU_SLL;
      3'b010:  f_alu = ALU_SLT;
      3'b011:  f_alu = ALU_SLTU;
      3'b100:  f_alu = ALU_XOR;
      3'b101:  f_alu = alt ? ALU_SRA : ALU_SRL;
      3'b110:  f_alu = ALU_OR;
      default: f_alu = ALU_AND;
    endcase
  endfunction

  function automatic mem_op_e f_mem(input logic [1:0] sz);
    case (sz)
      2'b00:   f_mem = MEM_B;
      2'b01:   f_mem = MEM_H;
      2'b10:   f_mem = MEM_W;
      default: f_mem = MEM_NOP;
    endcase
  endfunction

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_imm;
  control_t    w_ctrl;
  logic        w_legal, w_muldiv, w_ecall, w_ebreak;
  pkt_t        w_pkt;

  assign w_opcode = in_instr[6:0];
  assign w_f3     = in_instr[14:12];
  assign w_f7     = in_instr[31:25];
  assign w_imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign w_imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
  assign w_imm_u  = {in_instr[31:12], 12'b0};
  assign w_imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};

  always_comb begin
    w_ctrl   = '0;
    w_imm    = '0;
    w_legal  = 1'b0;
    w_muldiv = 1'b0;
    w_ecall  = 1'b0;
    w_ebreak = 1'b0;
    case (w_opcode)
      OP_LUI: begin
        w_legal          = 1'b1;
        w_ctrl.alu_op    = ALU_COPY;
        w_ctrl.alu_src_b = ALU_SRC_IMM;
        w_ctrl.reg_write = 1'b1;
        w_imm            = w_imm_u;
      end
      OP_AUIPC: begin
        w_legal          = 1'b1;
        w_ctrl.alu_src_a = ALU_SRC_PC;
        w_ctrl.alu_src_b = ALU_SRC_IMM;
        w_ctrl.reg_write = 1'b1;
        w_imm            = w_imm_u;
      end
      OP_JAL: begin
        w_legal          = 1'b1;
        w_ctrl.jump      = 1'b1;
        w_ctrl.wb_src    = WB_SRC_PC4;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src_a = ALU_SRC_PC;
        w_ctrl.alu_src_b = ALU_SRC_IMM;
        w_imm            = w_imm_j;
      end
      OP_JALR: begin
        w_legal          = (w_f3 == 3'b000);
        w_ctrl.jalr      = 1'b1;
        w_ctrl.wb_src    = WB_SRC_PC4;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src_b = ALU_SRC_IMM;
        w_imm            = w_imm_i;
      end
      OP_BRANCH: begin
        w_legal       = (w_f3[2:1] != 2'b01);
        w_ctrl.branch = 1'b1;
        w_ctrl.br_op  = w_f3;
        w_ctrl.alu_op = !w_f3[2] ? ALU_SUB : (w_f3[1] ? ALU_SLTU : ALU_SLT);
        w_imm         = w_imm_b;
      end
      OP_LOAD: begin
        w_legal            = (w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b010) ||
                             (w_f3 == 3'b100) || (w_f3 == 3'b101);
        w_ctrl.mem_read    = 1'b1;
        w_ctrl.reg_write   = 1'b1;
        w_ctrl.wb_src      = WB_SRC_MEM;
        w_ctrl.alu_src_b   = ALU_SRC_IMM;
        w_ctrl.mem_op      = f_mem(w_f3[1:0]);
        w_ctrl.is_unsigned = w_f3[2];
        w_imm              = w_imm_i;
      end
      OP_STORE: begin
        w_legal          = !w_f3[2] && (w_f3[1:0] != 2'b11);
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_src_b = ALU_SRC_IMM;
        w_ctrl.mem_op    = f_mem(w_f3[1:0]);
        w_imm            = w_imm_s;
      end
      OP_ALUI: begin
        // Only shifts carry funct7; instr[30] is an immediate bit otherwise.
        if (w_f3 == 3'b001)      w_legal = (w_f7 == 7'b0000000);
        else if (w_f3 == 3'b101) w_legal = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
        else                     w_legal = 1'b1;
        w_ctrl.alu_op    = f_alu(w_f3, (w_f3 == 3'b101) && in_instr[30]);
        w_ctrl.alu_src_b = ALU_SRC_IMM;
        w_ctrl.reg_write = 1'b1;
        w_imm            = w_imm_i;
      end
      OP_ALU: begin
        w_ctrl.reg_write = 1'b1;
        if (w_f7 == 7'b0000001) begin
          w_legal  = ENABLE_M;
          w_muldiv = 1'b1;
        end else begin
          w_legal = (w_f7 == 7'b0000000) ||
                    ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
          w_ctrl.alu_op = f_alu(w_f3, in_instr[30]);
        end
      end
      OP_FENCE: w_legal = 1'b1;
      OP_SYSTEM: begin
        w_ecall  = (in_instr == 32'h0000_0073);
        w_ebreak = (in_instr == 32'h0010_0073);
        w_legal  = w_ecall || w_ebreak;
        w_imm    = w_imm_i;
      end
      default: w_legal = 1'b0;
    endcase
    if (in_instr[1:0] != 2'b11) w_legal = 1'b0;
    if (!w_legal) begin
      w_ctrl.reg_write = 1'b0;
      w_ctrl.mem_read  = 1'b0;
      w_ctrl.mem_write = 1'b0;
      w_ctrl.branch    = 1'b0;
      w_ctrl.jump      = 1'b0;
      w_ctrl.jalr      = 1'b0;
      w_muldiv         = 1'b0;
      w_ecall          = 1'b0;
      w_ebreak         = 1'b0;
    end
    if (in_instr[11:7] == 5'd0) w_ctrl.reg_write = 1'b0;
  end

  always_comb begin
    w_pkt           = '0;
    w_pkt.pc        = in_pc;
    w_pkt.rs1       = in_instr[19:15];
    w_pkt.rs2       = in_instr[24:20];
    w_pkt.rd        = in_instr[11:7];
    w_pkt.imm       = w_imm;
    w_pkt.ctrl      = w_ctrl;
    w_pkt.is_muldiv = w_muldiv;
    w_pkt.muldiv_op = w_muldiv ? w_f3 : 3'b000;
    w_pkt.ecall     = w_ecall;
    w_pkt.ebreak    = w_ebreak;
    w_pkt.illegal   = !w_legal;
  end

  logic                 r_out_valid, r_skid_full;
  pkt_t                 r_out, r_skid;
  logic [ILL_CNT_W-1:0] r_ill_count;
  logic                 w_accept, w_pop;

  assign w_accept = in_valid && !r_skid_full;
  assign w_pop    = r_out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_skid_full <= 1'b0;
      r_out       <= '0;
      r_skid      <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_skid_full <= 1'b0;
    end else if (r_skid_full) begin
      if (out_ready) begin
        r_out       <= r_skid;
        r_skid_full <= 1'b0;
      end
    end else if (w_accept) begin
      if (!r_out_valid || out_ready) begin
        r_out       <= w_pkt;
        r_out_valid <= 1'b1;
      end else begin
        r_skid      <= w_pkt;
        r_skid_full <= 1'b1;
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Counts consumption, so it still ticks in a flush cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ill_count <= '0;
    end else if (w_pop && r_out.illegal && (r_ill_count != {ILL_CNT_W{1'b1}})) begin
      r_ill_count <= r_ill_count + 1'b1;
    end
  end

  assign in_ready      = !r_skid_full;
  assign out_valid     = r_out_valid;
  assign out_pc        = r_out.pc;
  assign out_rs1       = r_out.rs1;
  assign out_rs2       = r_out.rs2;
  assign out_rd        = r_out.rd;
  assign out_imm       = r_out.imm;
  assign out_ctrl      = r_out.ctrl;
  assign out_is_muldiv = r_out.is_muldiv;
  assign out_muldiv_op = r_out.muldiv_op;
  assign out_ecall     = r_out.ecall;
  assign out_ebreak    = r_out.ebreak;
  assign out_illegal   = r_out.illegal;
  assign ill_count     = r_ill_count;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vector table plus handshake, flush,
// counter saturation and asynchronous reset sequences.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        d0_in_ready, d0_out_valid, d0_is_muldiv, d0_ecall, d0_ebreak, d0_illegal;
  logic [31:0] d0_pc, d0_imm;
  logic [4:0]  d0_rs1, d0_rs2, d0_rd;
  logic [2:0]  d0_mop;
  control_t    d0_ctrl;
  logic [15:0] d0_cnt;

  logic        d1_in_ready, d1_out_valid, d1_is_muldiv, d1_ecall, d1_ebreak, d1_illegal;
  logic [31:0] d1_pc, d1_imm;
  logic [4:0]  d1_rs1, d1_rs2, d1_rd;
  logic [2:0]  d1_mop;
  control_t    d1_ctrl;
  logic [15:0] d1_cnt;

  logic        d2_in_ready, d2_out_valid, d2_is_muldiv, d2_ecall, d2_ebreak, d2_illegal;
  logic [31:0] d2_pc, d2_imm;
  logic [4:0]  d2_rs1, d2_rs2, d2_rd;
  logic [2:0]  d2_mop;
  control_t    d2_ctrl;
  logic [1:0]  d2_cnt;

  decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .ILL_CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(d0_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(d0_out_valid), .out_ready(out_ready),
    .out_pc(d0_pc), .out_rs1(d0_rs1), .out_rs2(d0_rs2), .out_rd(d0_rd), .out_imm(d0_imm),
    .out_ctrl(d0_ctrl), .out_is_muldiv(d0_is_muldiv), .out_muldiv_op(d0_mop),
    .out_ecall(d0_ecall), .out_ebreak(d0_ebreak), .out_illegal(d0_illegal),
    .ill_count(d0_cnt)
  );

  decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .ILL_CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(d1_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(d1_out_valid), .out_ready(out_ready),
    .out_pc(d1_pc), .out_rs1(d1_rs1), .out_rs2(d1_rs2), .out_rd(d1_rd), .out_imm(d1_imm),
    .out_ctrl(d1_ctrl), .out_is_muldiv(d1_is_muldiv), .out_muldiv_op(d1_mop),
    .out_ecall(d1_ecall), .out_ebreak(d1_ebreak), .out_illegal(d1_illegal),
    .ill_count(d1_cnt)
  );

  decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .ILL_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(d2_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(d2_out_valid), .out_ready(out_ready),
    .out_pc(d2_pc), .out_rs1(d2_rs1), .out_rs2(d2_rs2), .out_rd(d2_rd), .out_imm(d2_imm),
    .out_ctrl(d2_ctrl), .out_is_muldiv(d2_is_muldiv), .out_muldiv_op(d2_mop),
    .out_ecall(d2_ecall), .out_ebreak(d2_ebreak), .out_illegal(d2_illegal),
    .ill_count(d2_cnt)
  );

  always #5 clk = ~clk;

  // flags: {ill, rw, mrd, mwr, br, jmp, jalr, ecall, ebreak, uns, b_imm, a_pc, wb_pc4, md}
  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [13:0] flags;
    logic [31:0] imm;
    logic [4:0]  rd;
    alu_op_e     alu;
    bit          chk_imm;
    bit          chk_alu;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(string n, logic [31:0] i, logic [13:0] f, logic [31:0] imm,
                              logic [4:0] rd, alu_op_e a, bit ci, bit ca);
    vec_t v;
    v.name = n; v.instr = i; v.flags = f; v.imm = imm; v.rd = rd; v.alu = a;
    v.chk_imm = ci; v.chk_alu = ca;
    return v;
  endfunction

  function automatic logic [13:0] d0_flags();
    return {d0_illegal, d0_ctrl.reg_write, d0_ctrl.mem_read, d0_ctrl.mem_write,
            d0_ctrl.branch, d0_ctrl.jump, d0_ctrl.jalr, d0_ecall, d0_ebreak,
            d0_ctrl.is_unsigned, d0_ctrl.alu_src_b == ALU_SRC_IMM,
            d0_ctrl.alu_src_a == ALU_SRC_PC, d0_ctrl.wb_src == WB_SRC_PC4, d0_is_muldiv};
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vq[$];

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 32'h0; in_pc = 32'h0;
    step(); step();
    check("rst_out_valid", 32'(d0_out_valid), 32'd0);
    check("rst_in_ready", 32'(d0_in_ready), 32'd1);
    check("rst_ill_count", 32'(d0_cnt), 32'd0);
    check("rst_ctrl", 32'(d0_ctrl), 32'd0);
    check("rst_imm_pc", d0_imm | d0_pc, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Streaming ADDI x1,x0,5 then ADD x2,x1,x1
    in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h0;
    step();
    check("s1_valid", 32'(d0_out_valid), 32'd1);
    check("s1_imm", d0_imm, 32'd5);
    check("s1_rd", 32'(d0_rd), 32'd1);
    check("s1_alu", 32'(d0_ctrl.alu_op), 32'(ALU_ADD));
    check("s1_rw", 32'(d0_ctrl.reg_write), 32'd1);
    check("s1_srcb", 32'(d0_ctrl.alu_src_b), 32'(ALU_SRC_IMM));
    in_instr = 32'h0010_8133; in_pc = 32'h4;
    step();
    in_valid = 1'b0;
    check("s2_valid", 32'(d0_out_valid), 32'd1);
    check("s2_pc", d0_pc, 32'h4);
    check("s2_rd", 32'(d0_rd), 32'd2);
    check("s2_rs", {d0_rs1, d0_rs2}, {5'd1, 5'd1});
    check("s2_srcb", 32'(d0_ctrl.alu_src_b), 32'(ALU_SRC_REG));
    step();
    check("s3_empty", 32'(d0_out_valid), 32'd0);

    // MUL with and without the M extension
    in_valid = 1'b1; in_instr = 32'h0220_8033; in_pc = 32'h8;
    step();
    in_valid = 1'b0;
    check("mul_m0_illegal", 32'(d0_illegal), 32'd1);
    check("mul_m0_rw", 32'(d0_ctrl.reg_write), 32'd0);
    check("mul_m0_cnt_before", 32'(d0_cnt), 32'd0);
    check("mul_m1_muldiv", 32'(d1_is_muldiv), 32'd1);
    check("mul_m1_op", 32'(d1_mop), 32'd0);
    check("mul_m1_illegal", 32'(d1_illegal), 32'd0);
    step();
    check("mul_m0_cnt_after", 32'(d0_cnt), 32'd1);
    check("mul_m1_cnt_after", 32'(d1_cnt), 32'd0);

    vq.push_back(mk("addi_x1",  32'h0050_0093, 14'b0_1_0_0_0_0_0_0_0_0_1_0_0_0, 32'd5, 5'd1, ALU_ADD, 1, 1));
    vq.push_back(mk("add",      32'h0010_8133, 14'b0_1_0_0_0_0_0_0_0_0_0_0_0_0, 32'd0, 5'd2, ALU_ADD, 1, 1));
    vq.push_back(mk("sub",      32'h4020_81B3, 14'b0_1_0_0_0_0_0_0_0_0_0_0_0_0, 32'd0, 5'd3, ALU_SUB, 1, 1));
    vq.push_back(mk("lui",      32'h1234_52B7, 14'b0_1_0_0_0_0_0_0_0_0_1_0_0_0, 32'h1234_5000, 5'd5, ALU_COPY, 1, 1));
    vq.push_back(mk("auipc",    32'h0000_1217, 14'b0_1_0_0_0_0_0_0_0_0_1_1_0_0, 32'h0000_1000, 5'd4, ALU_ADD, 1, 1));
    vq.push_back(mk("lbu",      32'hFFF0_C183, 14'b0_1_1_0_0_0_0_0_0_1_1_0_0_0, 32'hFFFF_FFFF, 5'd3, ALU_ADD, 1, 1));
    vq.push_back(mk("sw",       32'h0020_A423, 14'b0_0_0_1_0_0_0_0_0_0_1_0_0_0, 32'd8, 5'd8, ALU_ADD, 1, 1));
    vq.push_back(mk("bltu",     32'h0020_E863, 14'b0_0_0_0_1_0_0_0_0_0_0_0_0_0, 32'd16, 5'd16, ALU_SLTU, 1, 1));
    vq.push_back(mk("jal",      32'h0080_00EF, 14'b0_1_0_0_0_1_0_0_0_0_1_1_1_0, 32'd8, 5'd1, ALU_ADD, 1, 1));
    vq.push_back(mk("srai",     32'h4030_D093, 14'b0_1_0_0_0_0_0_0_0_0_1_0_0_0, 32'h403, 5'd1, ALU_SRA, 1, 1));
    vq.push_back(mk("addi_x0",  32'h0000_0013, 14'b0_0_0_0_0_0_0_0_0_0_1_0_0_0, 32'd0, 5'd0, ALU_ADD, 1, 1));
    vq.push_back(mk("ecall",    32'h0000_0073, 14'b0_0_0_0_0_0_0_1_0_0_0_0_0_0, 32'd0, 5'd0, ALU_ADD, 1, 1));
    vq.push_back(mk("ebreak",   32'h0010_0073, 14'b0_0_0_0_0_0_0_0_1_0_0_0_0_0, 32'd0, 5'd0, ALU_ADD, 0, 1));
    vq.push_back(mk("fence",    32'h0FF0_000F, 14'b0_0_0_0_0_0_0_0_0_0_0_0_0_0, 32'd0, 5'd0, ALU_ADD, 0, 1));
    vq.push_back(mk("slli_bad", 32'h4000_1013, 14'b1_0_0_0_0_0_0_0_0_0_1_0_0_0, 32'h400, 5'd0, ALU_SLL, 1, 1));
    vq.push_back(mk("br_f3_2",  32'h0020_A863, 14'b1_0_0_0_0_0_0_0_0_0_0_0_0_0, 32'd16, 5'd16, ALU_ADD, 1, 0));
    vq.push_back(mk("jalr_f3",  32'h0000_90E7, 14'b1_0_0_0_0_0_0_0_0_0_1_0_1_0, 32'd0, 5'd1, ALU_ADD, 1, 1));
    vq.push_back(mk("or_alt",   32'h4020_E1B3, 14'b1_0_0_0_0_0_0_0_0_0_0_0_0_0, 32'd0, 5'd3, ALU_ADD, 1, 0));
    vq.push_back(mk("ld_f3_3",  32'h0000_B183, 14'b1_0_0_0_0_0_0_0_0_0_1_0_0_0, 32'd0, 5'd3, ALU_ADD, 1, 1));
    vq.push_back(mk("csrrw",    32'h3000_1073, 14'b1_0_0_0_0_0_0_0_0_0_0_0_0_0, 32'd0, 5'd0, ALU_ADD, 0, 1));
    vq.push_back(mk("low_bits", 32'h0000_0012, 14'b1_0_0_0_0_0_0_0_0_0_0_0_0_0, 32'd0, 5'd0, ALU_ADD, 1, 1));

    for (int i = 0; i < vq.size(); i++) begin
      in_valid = 1'b1; in_instr = vq[i].instr; in_pc = 32'h1000 + 32'(i) * 4;
      step();
      in_valid = 1'b0;
      check({vq[i].name, "_valid"}, 32'(d0_out_valid), 32'd1);
      check({vq[i].name, "_pc"}, d0_pc, 32'h1000 + 32'(i) * 4);
      check({vq[i].name, "_flags"}, 32'(d0_flags()), 32'(vq[i].flags));
      check({vq[i].name, "_rd"}, 32'(d0_rd), 32'(vq[i].rd));
      if (vq[i].chk_imm) check({vq[i].name, "_imm"}, d0_imm, vq[i].imm);
      if (vq[i].chk_alu) check({vq[i].name, "_alu"}, 32'(d0_ctrl.alu_op), 32'(vq[i].alu));
      step();
    end

    // Backpressure: output + skid fill, third instruction held off
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h100;
    step();
    check("bp1_in_ready", 32'(d0_in_ready), 32'd1);
    check("bp1_pc", d0_pc, 32'h100);
    in_instr = 32'h0010_8133; in_pc = 32'h104;
    step();
    check("bp2_in_ready", 32'(d0_in_ready), 32'd0);
    check("bp2_pc", d0_pc, 32'h100);
    in_instr = 32'h4020_81B3; in_pc = 32'h108;
    step();
    check("bp3_held_pc", d0_pc, 32'h100);
    check("bp3_in_ready", 32'(d0_in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    check("bp4_pc", d0_pc, 32'h104);
    check("bp4_rd", 32'(d0_rd), 32'd2);
    check("bp4_in_ready", 32'(d0_in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("bp5_pc", d0_pc, 32'h108);
    check("bp5_rd", 32'(d0_rd), 32'd3);
    check("bp5_valid", 32'(d0_out_valid), 32'd1);
    step();
    check("bp6_empty", 32'(d0_out_valid), 32'd0);

    // Flush while in SKID with an instruction offered
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h200;
    step();
    in_pc = 32'h204;
    step();
    check("fl_skid_in_ready", 32'(d0_in_ready), 32'd0);
    flush = 1'b1; in_pc = 32'h208;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", 32'(d0_out_valid), 32'd0);
    check("fl_in_ready", 32'(d0_in_ready), 32'd1);
    out_ready = 1'b1;
    step();
    check("fl_no_ghost1", 32'(d0_out_valid), 32'd0);
    step();
    check("fl_no_ghost2", 32'(d0_out_valid), 32'd0);

    // Saturation of a 2-bit counter over five consumed illegal packets
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0000_0012; in_pc = 32'h300;
    for (int i = 0; i < 5; i++) step();
    in_valid = 1'b0;
    step(); step();
    check("sat_cnt_w2", 32'(d2_cnt), 32'd3);
    check("sat_cnt_w16", 32'(d0_cnt), 32'd5);

    // Asynchronous reset between edges while in SKID
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h400;
    step(); step();
    in_valid = 1'b0;
    check("ar_pre_in_ready", 32'(d0_in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", 32'(d0_out_valid), 32'd0);
    check("ar_in_ready", 32'(d0_in_ready), 32'd1);
    check("ar_cnt", 32'(d0_cnt), 32'd0);
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered instruction-decode pipeline stage between fetch and execute. It decodes RV32I, plus RV32M when enabled, into the shared control_t bundle, register addresses and immediate.
- Adds three things the combinational decoder lacks: a valid/ready handshake with a one-entry skid buffer, a pipeline flush, and strict legality checking with a saturating illegal-instruction counter.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- ENABLE_M, 0, when 1, OP_ALU with funct7=0000001 decodes as MUL/DIV; when 0, it is illegal.
- ILL_CNT_W, 16, width of the illegal-instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- flush  in  1  discard all held and incoming instructions this cycle
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept; driven from a register only (~skid_full)
- in_instr  in  32  instruction word
- in_pc  in  XLEN  PC of in_instr
- out_valid  out  1  decoded packet valid
- out_ready  in  1  execute accepts the packet
- out_pc  out  XLEN  PC of the packet
- out_rs1, out_rs2, out_rd  out  5 each  register addresses
- out_imm  out  XLEN  immediate (I/S/B/U/J per opcode, else 0)
- out_ctrl  out  control_t  control bundle
- out_is_muldiv  out  1  RV32M operation
- out_muldiv_op  out  3  funct3 of the M operation
- out_ecall, out_ebreak  out  1 each  system trap requests
- out_illegal  out  1  packet is an illegal instruction
- ill_count  out  ILL_CNT_W  saturating count of illegal packets consumed

Behaviour:
- Reset (async, rst=1): out_valid=0, skid_full=0, in_ready=1, ill_count=0. All payload outputs are 0 and out_ctrl equals the decoder defaults: alu_op=ALU_ADD, all enables 0, mem_op=MEM_NOP.
- Accept condition: in_valid && in_ready.
- Latency: decode is combinational on in_instr; the result is registered. A packet accepted in cycle N appears at the output in cycle N+1.
- Occupancy states and transitions:
  - EMPTY (out_valid=0).
    - Accept -> FULL.
  - FULL (out_valid=1, skid_full=0).
    - Accept and out_ready=1: output reloads with the new packet; stay FULL.
    - Accept and out_ready=0: new packet goes to the skid register -> SKID.
    - No accept and out_ready=1 -> EMPTY.
  - SKID (out_valid=1, skid_full=1, in_ready=0).
    - out_ready=1: skid moves to the output -> FULL.
- Ordering: packets leave strictly in arrival order. The output never changes while out_valid && !out_ready.
- flush: highest priority. Next state is EMPTY and the same-cycle input is dropped. ill_count still counts an illegal packet consumed in the flush cycle (out_valid && out_ready && out_illegal).
- Field decode:
  - Register fields and immediates use the standard RV32I bit positions.
  - LUI: ALU_COPY with imm_u.
  - AUIPC: PC + imm_u.
  - JAL: jump, WB_SRC_PC4.
  - JALR: jalr, WB_SRC_PC4, imm_i.
  - Branches: ALU_SUB, ALU_SLT or ALU_SLTU by funct3.
  - Loads and stores: ALU_ADD, mem_op by funct3; is_unsigned=1 only for LBU/LHU.
- Legality (any failure sets out_illegal=1):
  - instr[1:0] must be 11.
  - Opcode must be one of LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, ALUI, ALU, FENCE, SYSTEM.
  - JALR requires funct3=000.
  - BRANCH rejects funct3 010 and 011.
  - LOAD allows only 000, 001, 010, 100, 101.
  - STORE allows only 000, 001, 010.
  - SLLI requires funct7=0000000.
  - SRLI/SRAI require funct7 of 0000000 or 0100000.
  - OP_ALU requires funct7=0000000 for all funct3. 0100000 is allowed only for funct3 000 or 101. 0000001 is allowed only if ENABLE_M=1.
  - SYSTEM: only 0x00000073 (ECALL) and 0x00100073 (EBREAK) are legal. All CSR and other encodings are illegal; this block has no CSR support.
- Illegal packets: carry out_pc and in_instr-derived fields as usual, but force reg_write, mem_read, mem_write, branch, jump, jalr, out_is_muldiv, out_ecall and out_ebreak to 0.
- Writes to x0: reg_write is forced to 0 when rd=0, for all opcodes.
- FENCE: legal NOP; all enables 0.
- M operations: reg_write=1, out_is_muldiv=1, out_muldiv_op=funct3, alu_op left at ALU_ADD.
- ill_count: +1 on out_valid && out_ready && out_illegal; saturates at all-ones with no wrap.

Test Plan:
- Streaming: ADDI x1,x0,5 (0x00500093) then ADD x2,x1,x1 (0x00108133), out_ready=1 every cycle -> out_valid one cycle after each accept; first packet imm=5, rd=1, alu_op=ALU_ADD, reg_write=1, alu_src_b=ALU_SRC_IMM; second packet rd=2, alu_src_b=ALU_SRC_REG; in order, no bubbles.
- Backpressure: out_ready=0 while three instructions are offered -> the first two are held (output + skid), in_ready=0 on the cycle after the skid fills, third not taken; releasing out_ready delivers all three in order, none dropped or duplicated.
- Flush in SKID: flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; the dropped instruction never appears.
- Illegal: 0x02208033 (MUL) with ENABLE_M=0 -> out_illegal=1, reg_write=0, ill_count 0->1. With ENABLE_M=1 -> out_is_muldiv=1, out_muldiv_op=000, out_illegal=0. Also 0x40001013 (SLLI, funct7=0100000) -> illegal; 0x00000073 -> out_ecall=1.
- x0 write: 0x00000013 (ADDI x0,x0,0) -> reg_write=0, out_illegal=0. Saturation: ILL_CNT_W=2, five illegal packets consumed -> ill_count=3.
- Async reset mid-stream: assert rst between clock edges while in SKID -> out_valid=0, ill_count=0 and in_ready=1 immediately, without waiting for a clock edge.
